bcd_serial_addsub: RTL and testbench

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

---
 rtl/bcd_serial_addsub_pkg.sv | 7 +
 rtl/bcd_digit_add.sv | 21 ++
 rtl/bcd_serial_addsub.sv | 108 ++++++++++
 tb/tb_bcd_serial_addsub.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
package bcd_serial_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int BCD_W = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_SIX = 4'd6;
endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit add with decimal correction and invalid-digit flag.
import bcd_serial_addsub_pkg::*;

module bcd_digit_add (
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             ci,
    output logic [BCD_W-1:0] d,
    output logic             co,
    output logic             bad
);
    logic [BCD_W:0] s;

    always_comb begin
        s   = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
        co  = s > {1'b0, BCD_NINE};
        d   = co ? s[BCD_W-1:0] + BCD_SIX : s[BCD_W-1:0];
        // a nine's-complemented invalid b digit stays above nine
        bad = (a > BCD_NINE) || (b > BCD_NINE);
    end
endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD add/subtract processing DPC digits per clock.
import bcd_serial_addsub_pkg::*;

module bcd_serial_addsub #(
    parameter int DIGITS = 100,
    parameter int DPC    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    cin,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    err
);
    localparam int W     = BCD_W * DIGITS;
    localparam int G     = BCD_W * DPC;
    localparam int BEATS = DIGITS / DPC;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t          state;
    logic [W-1:0]    a_q, b_q, res_q, res_next;
    logic            sub_q, carry_q, err_q;
    logic [CW-1:0]   beat_q;
    logic [DPC:0]    c;
    logic [G-1:0]    grp_b, grp_d;
    logic [DPC-1:0]  bad;
    logic            last;

    assign c[0] = carry_q;

    for (genvar i = 0; i < DPC; i++) begin : g_dig
        assign grp_b[BCD_W*i +: BCD_W] = sub_q
            ? BCD_NINE - b_q[BCD_W*i +: BCD_W]
            : b_q[BCD_W*i +: BCD_W];

        bcd_digit_add u_dig (
            .a   (a_q[BCD_W*i +: BCD_W]),
            .b   (grp_b[BCD_W*i +: BCD_W]),
            .ci  (c[i]),
            .d   (grp_d[BCD_W*i +: BCD_W]),
            .co  (c[i+1]),
            .bad (bad[i])
        );
    end

    // result fills from the top so the LSD group lands at bit 0
    assign res_next = (W'(grp_d) << (W - G)) | (res_q >> G);
    assign last     = beat_q == CW'(BEATS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid && in_ready) begin
                    a_q      <= a;
                    b_q      <= b;
                    sub_q    <= sub;
                    carry_q  <= sub ? ~cin : cin;
                    err_q    <= 1'b0;
                    beat_q   <= '0;
                    state    <= RUN;
                    in_ready <= 1'b0;
                end
                RUN: begin
                    a_q     <= a_q >> G;
                    b_q     <= b_q >> G;
                    res_q   <= res_next;
                    carry_q <= c[DPC];
                    err_q   <= err_q | (|bad);
                    beat_q  <= beat_q + 1'b1;
                    if (last) begin
                        sum       <= res_next;
                        cout      <= sub_q ^ c[DPC];
                        err       <= err_q | (|bad);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench: small (4x1) instance for directed cases, default instance for random.
module tb_bcd_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        s_in_valid, s_in_ready, s_cin, s_sub;
    logic        s_out_valid, s_out_ready, s_cout, s_err;
    logic [15:0] s_a, s_b, s_sum;

    logic         g_in_valid, g_in_ready, g_cin, g_sub;
    logic         g_out_valid, g_out_ready, g_cout, g_err;
    logic [399:0] g_a, g_b, g_sum;

    bcd_serial_addsub #(.DIGITS(4), .DPC(1)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .err(s_err)
    );

    bcd_serial_addsub u_big (
        .clk(clk), .rst(rst),
        .in_valid(g_in_valid), .in_ready(g_in_ready),
        .a(g_a), .b(g_b), .cin(g_cin), .sub(g_sub),
        .out_valid(g_out_valid), .out_ready(g_out_ready),
        .sum(g_sum), .cout(g_cout), .err(g_err)
    );

    // decimal reference: schoolbook add, or borrow subtraction (wraps to ten's complement)
    function automatic void model(input logic [399:0] a, input logic [399:0] b,
                                  input logic cin, input logic sub, input int n,
                                  output logic [399:0] s, output logic co);
        int c;
        int d;
        c = int'(cin);
        s = '0;
        for (int i = 0; i < n; i++) begin
            if (!sub) begin
                d = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
                c = d / 10;
                d = d % 10;
            end else begin
                d = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - c;
                c = (d < 0) ? 1 : 0;
                if (d < 0) d += 10;
            end
            s[4*i +: 4] = d[3:0];
        end
        co = c[0];
    endfunction

    function automatic logic [399:0] rand_digits(input int n);
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
        return v;
    endfunction

    task automatic run_small(input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub, output int lat,
                             output logic [15:0] sum, output logic co, output logic er);
        s_a = a; s_b = b; s_cin = cin; s_sub = sub;
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_a = 16'($urandom); s_b = 16'($urandom);
        s_cin = 1'($urandom); s_sub = 1'($urandom);
        lat = 0;
        while (!s_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = s_sum; co = s_cout; er = s_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got rdy=%b vld=%b want 1 0", s_in_ready, s_out_valid);
        end
        checks++;
        if (s_sum !== 16'h0 || s_cout !== 1'b0 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got %h %b %b want 0000 0 0", s_sum, s_cout, s_err);
        end
        checks++;
        if (g_in_ready !== 1'b1 || g_out_valid !== 1'b0 || g_sum !== '0) begin
            errors++;
            $display("FAIL reset_big got rdy=%b vld=%b", g_in_ready, g_out_valid);
        end
    endtask

    task automatic test_add;
        int lat; logic [15:0] s; logic co, er;
        run_small(16'h9999, 16'h0001, 1'b0, 1'b0, lat, s, co, er);
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL add_9999 got %h c%b e%b want 0000 c1 e0", s, co, er);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency got %0d want 4", lat);
        end
    endtask

    task automatic test_sub;
        int lat; logic [15:0] s; logic co, er;
        run_small(16'h0100, 16'h0001, 1'b0, 1'b1, lat, s, co, er);
        checks++;
        if (s !== 16'h0099 || co !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL sub_pos got %h c%b l%0d want 0099 c0 l4", s, co, lat);
        end
        run_small(16'h0001, 16'h0002, 1'b0, 1'b1, lat, s, co, er);
        checks++;
        if (s !== 16'h9999 || co !== 1'b1) begin
            errors++;
            $display("FAIL sub_neg got %h c%b want 9999 c1", s, co);
        end
    endtask

    task automatic test_invalid;
        int lat; logic [15:0] s; logic co, er;
        run_small(16'h000A, 16'h0000, 1'b0, 1'b0, lat, s, co, er);
        checks++;
        if (s !== 16'h0010 || co !== 1'b0 || er !== 1'b1) begin
            errors++;
            $display("FAIL invalid_digit got %h c%b e%b want 0010 c0 e1", s, co, er);
        end
        run_small(16'h0005, 16'h0003, 1'b0, 1'b0, lat, s, co, er);
        checks++;
        if (s !== 16'h0008 || er !== 1'b0) begin
            errors++;
            $display("FAIL invalid_clear got %h e%b want 0008 e0", s, er);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        s_a = 16'h0250; s_b = 16'h0250; s_cin = 1'b0; s_sub = 1'b0;
        s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(posedge clk); #1;
        s_a = 16'h0456; s_b = 16'h0544;
        lat = 0;
        while (!s_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || s_sum !== 16'h0500 || s_cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_result got %h c%b l%0d want 0500 c0 l4", s_sum, s_cout, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_out_valid !== 1'b1 || s_sum !== 16'h0500 || s_cout !== 1'b0 || s_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got v%b %h c%b r%b want v1 0500 c0 r0",
                         i, s_out_valid, s_sum, s_cout, s_in_ready);
            end
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_sum !== 16'h0500) begin
            errors++;
            $display("FAIL bp_release got r%b v%b %h want r1 v0 0500", s_in_ready, s_out_valid, s_sum);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        checks++;
        if (s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept got r%b want 0", s_in_ready);
        end
        lat = 0;
        while (!s_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || s_sum !== 16'h1000 || s_cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_second got %h c%b l%0d want 1000 c0 l4", s_sum, s_cout, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int lat; int seen; logic [15:0] s; logic co, er;
        logic [399:0] ms; logic mc;
        s_a = 16'h1111; s_b = 16'h2222; s_cin = 1'b0; s_sub = 1'b0;
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_sum !== 16'h0 || s_cout !== 1'b0 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got r%b v%b %h c%b e%b want r1 v0 0000 c0 e0",
                     s_in_ready, s_out_valid, s_sum, s_cout, s_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s_out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result got %0d valid cycles want 0", seen);
        end
        run_small(16'h1234, 16'h8766, 1'b1, 1'b0, lat, s, co, er);
        model({384'b0, 16'h1234}, {384'b0, 16'h8766}, 1'b1, 1'b0, 4, ms, mc);
        checks++;
        if (s !== ms[15:0] || co !== mc || lat !== 4) begin
            errors++;
            $display("FAIL abort_fresh got %h c%b l%0d want %h c%b l4", s, co, lat, ms[15:0], mc);
        end
    endtask

    task automatic test_random_small;
        int lat; logic [15:0] s, ra, rb; logic co, er, rc, rs;
        logic [399:0] ms; logic mc;
        for (int n = 0; n < 30; n++) begin
            ra = rand_digits(4); rb = rand_digits(4);
            rc = 1'($urandom); rs = 1'($urandom);
            model({384'b0, ra}, {384'b0, rb}, rc, rs, 4, ms, mc);
            run_small(ra, rb, rc, rs, lat, s, co, er);
            checks++;
            if (s !== ms[15:0] || co !== mc || er !== 1'b0 || lat !== 4) begin
                errors++;
                $display("FAIL rand_small %h %s %h cin%b got %h c%b e%b l%0d want %h c%b e0 l4",
                         ra, rs ? "-" : "+", rb, rc, s, co, er, lat, ms[15:0], mc);
            end
        end
    endtask

    task automatic test_random_big;
        int lat; logic [399:0] ra, rb, ms; logic rc, rs, mc;
        for (int n = 0; n < 6; n++) begin
            ra = rand_digits(100); rb = rand_digits(100);
            rc = 1'($urandom); rs = n[0];
            model(ra, rb, rc, rs, 100, ms, mc);
            g_a = ra; g_b = rb; g_cin = rc; g_sub = rs;
            g_in_valid = 1'b1; g_out_ready = 1'b1;
            @(posedge clk); #1;
            g_in_valid = 1'b0;
            g_a = rand_digits(100); g_b = rand_digits(100);
            lat = 0;
            while (!g_out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 25) begin
                errors++;
                $display("FAIL big_latency op%0d got %0d want 25", n, lat);
            end
            checks++;
            if (g_sum !== ms || g_cout !== mc || g_err !== 1'b0) begin
                errors++;
                $display("FAIL big_result op%0d sub%b got c%b e%b low %h want c%b e0 low %h",
                         n, rs, g_cout, g_err, g_sum[63:0], mc, ms[63:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        g_in_valid = 1'b0; g_out_ready = 1'b1; g_a = '0; g_b = '0; g_cin = 1'b0; g_sub = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_add;
        test_sub;
        test_invalid;
        test_backpressure;
        test_reset_abort;
        test_random_small;
        test_random_big;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
